// File: rtl/fetch_pkg.sv
// Shared fetch-path types and widths.
// fetch_packet_t / bp_pack_t describe the default two-wide packet shape;
// modules built for other widths derive matching local types from the same
// field order using sel_width().
package fetch_pkg;

  localparam int INST_W          = 32;
  localparam int PC_W            = 64;
  localparam int BR_TYPE_W       = 4;
  localparam int FETCH_WIDTH_DEF = 2;

  // Slot-select width: log2 of the fetch width, never narrower than one bit.
  function automatic int sel_width(input int fw);
    return (fw > 1) ? $clog2(fw) : 1;
  endfunction

  localparam int SEL_W_DEF = sel_width(FETCH_WIDTH_DEF);

  typedef struct packed {
    logic                 valid;
    logic [PC_W-1:0]      target;
    logic [BR_TYPE_W-1:0] branch_type;
    logic [SEL_W_DEF-1:0] select;
    logic                 taken;
  } bp_pack_t;

  typedef struct packed {
    logic [FETCH_WIDTH_DEF-1:0]        valids;
    logic [PC_W-1:0]                   pc;
    logic [INST_W*FETCH_WIDTH_DEF-1:0] insts;
    bp_pack_t                          bp;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: enqueue side, dequeue side, status and flush.
// slave is the buffer's view, master is the fetch/decode environment's view.
interface fetch_buffer_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 4
);
  import fetch_pkg::*;

  localparam int SEL_W = sel_width(FETCH_WIDTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                        io_in_valid;
  logic                        io_in_ready;
  logic [FETCH_WIDTH-1:0]      io_in_bits_valids;
  logic [PC_W-1:0]             io_in_bits_pc;
  logic [INST_W*FETCH_WIDTH-1:0] io_in_bits_insts;
  logic                        io_in_bits_bp_valid;
  logic [PC_W-1:0]             io_in_bits_bp_target;
  logic [BR_TYPE_W-1:0]        io_in_bits_bp_branch_type;
  logic [SEL_W-1:0]            io_in_bits_bp_select;
  logic                        io_in_bits_bp_taken;

  logic                        io_out_valid;
  logic                        io_out_ready;
  logic [FETCH_WIDTH-1:0]      io_out_bits_valids;
  logic [PC_W-1:0]             io_out_bits_pc;
  logic [INST_W*FETCH_WIDTH-1:0] io_out_bits_insts;
  logic                        io_out_bits_bp_valid;
  logic [PC_W-1:0]             io_out_bits_bp_target;
  logic [BR_TYPE_W-1:0]        io_out_bits_bp_branch_type;
  logic [SEL_W-1:0]            io_out_bits_bp_select;
  logic                        io_out_bits_bp_taken;

  logic [CNT_W-1:0]            io_count;
  logic                        io_full;
  logic                        io_almost_full;
  logic                        io_i_flush;

  modport slave (
    input  io_in_valid, io_in_bits_valids, io_in_bits_pc, io_in_bits_insts,
           io_in_bits_bp_valid, io_in_bits_bp_target, io_in_bits_bp_branch_type,
           io_in_bits_bp_select, io_in_bits_bp_taken,
           io_out_ready, io_i_flush,
    output io_in_ready,
           io_out_valid, io_out_bits_valids, io_out_bits_pc, io_out_bits_insts,
           io_out_bits_bp_valid, io_out_bits_bp_target, io_out_bits_bp_branch_type,
           io_out_bits_bp_select, io_out_bits_bp_taken,
           io_count, io_full, io_almost_full
  );

  modport master (
    output io_in_valid, io_in_bits_valids, io_in_bits_pc, io_in_bits_insts,
           io_in_bits_bp_valid, io_in_bits_bp_target, io_in_bits_bp_branch_type,
           io_in_bits_bp_select, io_in_bits_bp_taken,
           io_out_ready, io_i_flush,
    input  io_in_ready,
           io_out_valid, io_out_bits_valids, io_out_bits_pc, io_out_bits_insts,
           io_out_bits_bp_valid, io_out_bits_bp_target, io_out_bits_bp_branch_type,
           io_out_bits_bp_select, io_out_bits_bp_taken,
           io_count, io_full, io_almost_full
  );

endinterface

// File: rtl/fetch_buffer_ram.sv
// Packet storage: DEPTH x WIDTH, one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module fetch_buffer_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the incoming packet into its slot on an enqueue.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular FIFO of fetch packets between fetch and decode.
// Head/tail pointers wrap modulo DEPTH; a separate count register gives
// occupancy, full and almost-full. Flush clears all pointers in one edge.
// Optional feature: define FETCH_BUFFER_BYPASS_EN to let a packet arriving at
// an empty buffer appear on the dequeue side in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FETCH_WIDTH  = 2,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic         clock,
  input  logic         reset,
  fetch_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SEL_W = sel_width(FETCH_WIDTH);

  typedef struct packed {
    logic                 valid;
    logic [PC_W-1:0]      target;
    logic [BR_TYPE_W-1:0] branch_type;
    logic [SEL_W-1:0]     select;
    logic                 taken;
  } bp_t;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0]        valids;
    logic [PC_W-1:0]               pc;
    logic [INST_W*FETCH_WIDTH-1:0] insts;
    bp_t                           bp;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  entry_t in_entry;
  entry_t rd_entry;
  entry_t out_entry;

  logic full;
  logic in_ready;
  logic out_valid;
  logic bypass_hit;
  logic enq;
  logic deq;

  // Gather the incoming payload into one storage word.
  always_comb begin
    in_entry                = '0;
    in_entry.valids         = bus.io_in_bits_valids;
    in_entry.pc             = bus.io_in_bits_pc;
    in_entry.insts          = bus.io_in_bits_insts;
    in_entry.bp.valid       = bus.io_in_bits_bp_valid;
    in_entry.bp.target      = bus.io_in_bits_bp_target;
    in_entry.bp.branch_type = bus.io_in_bits_bp_branch_type;
    in_entry.bp.select      = bus.io_in_bits_bp_select;
    in_entry.bp.taken       = bus.io_in_bits_bp_taken;
  end

  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = ~full & ~bus.io_i_flush & ~reset;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass_hit = (count == '0) & bus.io_in_valid & ~bus.io_i_flush & ~reset;
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid = ((count != '0) | bypass_hit) & ~bus.io_i_flush & ~reset;
  assign out_entry = bypass_hit ? in_entry : rd_entry;

  // A bypassed packet that is consumed immediately is never written.
  assign enq = bus.io_in_valid & in_ready & ~(bypass_hit & bus.io_out_ready);
  assign deq = out_valid & bus.io_out_ready & ~bypass_hit;

  fetch_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clock (clock),
    .we    (enq),
    .waddr (tail),
    .wdata (in_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  // Pointer and occupancy update; reset and flush both empty the buffer.
  always_ff @(posedge clock) begin
    if (reset || bus.io_i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  assign bus.io_in_ready                = in_ready;
  assign bus.io_out_valid               = out_valid;
  assign bus.io_out_bits_valids         = out_entry.valids;
  assign bus.io_out_bits_pc             = out_entry.pc;
  assign bus.io_out_bits_insts          = out_entry.insts;
  assign bus.io_out_bits_bp_valid       = out_entry.bp.valid;
  assign bus.io_out_bits_bp_target      = out_entry.bp.target;
  assign bus.io_out_bits_bp_branch_type = out_entry.bp.branch_type;
  assign bus.io_out_bits_bp_select      = out_entry.bp.select;
  assign bus.io_out_bits_bp_taken       = out_entry.bp.taken;
  assign bus.io_count                   = count;
  assign bus.io_full                    = full;
  assign bus.io_almost_full             = (count >= CNT_W'(AFULL_THRESH));

endmodule
